// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES shared constants, FSM state type and GF(2^8) helpers
package aes_pkg;

  localparam int AES_NB  = 4;
  localparam int STATE_W = 128;
  localparam int COL_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  // Multiply by 0x02 modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// rtl/inv_mix_column.sv - combinational InvMixColumns on one 32-bit column
// Byte layout: [31:24] is row 0, [7:0] is row 3.
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [7:0] a0, a1, a2, a3;

  function automatic logic [7:0] inv_row(input logic [7:0] r0, input logic [7:0] r1,
                                         input logic [7:0] r2, input logic [7:0] r3);
    return gf_mul(r0, 8'h0e) ^ gf_mul(r1, 8'h0b) ^ gf_mul(r2, 8'h0d) ^ gf_mul(r3, 8'h09);
  endfunction

  assign {a0, a1, a2, a3} = col_in;

  assign col_out = {inv_row(a0, a1, a2, a3),
                    inv_row(a1, a2, a3, a0),
                    inv_row(a2, a3, a0, a1),
                    inv_row(a3, a0, a1, a2)};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// rtl/inv_mix_columns_seq.sv - sequential AES InvMixColumns, one column per cycle
// Define INV_MIX_COLUMNS_PAR_EN to transform all four columns in one cycle.
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int N_COLS = AES_NB,
  parameter int CNT_W  = $clog2(N_COLS)
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] y
);

  fsm_state_t         state;
  fsm_state_t         state_next;
  logic               accept;
  logic               busy_last;
  logic [STATE_W-1:0] data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // In DONE, a taken result frees the unit in the same cycle, so a waiting
  // state is captured without passing through IDLE.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (busy_last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept     = 1'b1;
            state_next = BUSY;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef INV_MIX_COLUMNS_PAR_EN

  logic [STATE_W-1:0] par_out;

  for (genvar c = 0; c < N_COLS; c++) begin : g_core
    inv_mix_column u_core (
      .col_in  (data[STATE_W-1-COL_W*c -: COL_W]),
      .col_out (par_out[STATE_W-1-COL_W*c -: COL_W])
    );
  end

  assign busy_last = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                data <= '0;
    else if (accept)        data <= x;
    else if (state == BUSY) data <= par_out;
  end

`else

  logic [CNT_W-1:0] col_cnt;
  logic [COL_W-1:0] col_in;
  logic [COL_W-1:0] col_out;

  always_comb begin
    col_in = '0;
    for (int c = 0; c < N_COLS; c++) begin
      if (col_cnt == CNT_W'(c)) col_in = data[STATE_W-1-COL_W*c -: COL_W];
    end
  end

  inv_mix_column u_core (
    .col_in  (col_in),
    .col_out (col_out)
  );

  assign busy_last = (col_cnt == CNT_W'(N_COLS - 1));

  // Columns are rewritten in place, leftmost (column 0) first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= '0;
      col_cnt <= '0;
    end else if (accept) begin
      data    <= x;
      col_cnt <= '0;
    end else if (state == BUSY) begin
      for (int c = 0; c < N_COLS; c++) begin
        if (col_cnt == CNT_W'(c)) data[STATE_W-1-COL_W*c -: COL_W] <= col_out;
      end
      col_cnt <= busy_last ? '0 : col_cnt + 1'b1;
    end
  end

`endif

  assign y = data;

endmodule
